// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port between the pipeline writeback (primary) and a long-latency unit (secondary).
// Tracks outstanding secondary destinations; define GRF_WR_TRACE_EN to print every committed GRF write.
module grf_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        s_req,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    output logic        s_ack,
    input  logic        alloc_we,
    input  logic [4:0]  alloc_a3,
    output logic [31:0] busy,
    output logic        stall_pipe,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_waitCnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic [31:0]        r_busy;
    logic [31:0]        w_busyNext;
    logic               w_ack;
    logic               w_refused;

    assign w_ack      = reset & ~p_we & s_req;
    assign w_refused  = s_req & ~w_ack;
    assign s_ack      = w_ack;
    assign busy       = r_busy;
    assign stall_pipe = (r_state == FORCE);

    // $0 is never written, whichever side owns the port
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = p_a3;
        grf_wd = p_wd;
        grf_pc = p_pc;
        if (p_we) begin
            grf_we = (p_a3 != 5'd0);
        end else if (s_req) begin
            grf_we = (s_a3 != 5'd0);
            grf_a3 = s_a3;
            grf_wd = s_wd;
            grf_pc = s_pc;
        end
        if (!reset) begin
            grf_we = 1'b0;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_waitCnt;
        case (r_state)
            IDLE: begin
                if (w_refused) begin
                    w_cntNext   = CNT_W'(1);
                    w_stateNext = (MAX_WAIT == 1) ? FORCE : WAIT;
                end
            end
            WAIT: begin
                if (!w_refused) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_waitCnt + CNT_W'(1);
                    if (w_cntNext == CNT_W'(MAX_WAIT)) begin
                        w_stateNext = FORCE;
                    end
                end
            end
            FORCE: begin
                if (!w_refused) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // A fresh allocation overrides a completing write to the same register
    always_comb begin
        w_busyNext = r_busy;
        if (w_ack) begin
            w_busyNext[s_a3] = 1'b0;
        end
        if (alloc_we) begin
            w_busyNext[alloc_a3] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
            r_busy    <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_cntNext;
            r_busy    <= w_busyNext;
        end
    end

`ifdef GRF_WR_TRACE_EN
    always @(posedge clk) begin
        if (grf_we) begin
            $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
        end
    end
`else
    // No write trace in this build.
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Testbench for grf_write_arbiter: directed scenarios followed by randomized traffic
// checked against a streak/scoreboard reference model.
module tb_grf_write_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pWe;
    logic [4:0]  pA3;
    logic [31:0] pWd;
    logic [31:0] pPc;
    logic        sReq;
    logic [4:0]  sA3;
    logic [31:0] sWd;
    logic [31:0] sPc;
    logic        sAck;
    logic        allocWe;
    logic [4:0]  allocA3;
    logic [31:0] busy;
    logic        stall;
    logic        grfWe;
    logic [4:0]  grfA3;
    logic [31:0] grfWd;
    logic [31:0] grfPc;

    int          testsRun;
    int          testsFailed;
    logic [31:0] mBusy;
    int          mStreak;

    always #5 clk = ~clk;

    grf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .p_we(pWe), .p_a3(pA3), .p_wd(pWd), .p_pc(pPc),
        .s_req(sReq), .s_a3(sA3), .s_wd(sWd), .s_pc(sPc), .s_ack(sAck),
        .alloc_we(allocWe), .alloc_a3(allocA3),
        .busy(busy), .stall_pipe(stall),
        .grf_we(grfWe), .grf_a3(grfA3), .grf_wd(grfWd), .grf_pc(grfPc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc,
                                 input logic req, input logic [4:0] sa3, input logic [31:0] swd, input logic [31:0] spc,
                                 input logic aWe, input logic [4:0] aA3);
        pWe = we;   pA3 = a3;   pWd = wd;   pPc = pc;
        sReq = req; sA3 = sa3;  sWd = swd;  sPc = spc;
        allocWe = aWe; allocA3 = aA3;
    endtask

    // Expected port-sharing result from the current inputs
    task automatic checkComb(input string tag);
        logic        eAck;
        logic        eWe;
        logic        sWins;
        eAck  = reset && !pWe && sReq;
        sWins = !pWe && sReq;
        if (!reset)    eWe = 1'b0;
        else if (pWe)  eWe = (pA3 != 0);
        else if (sReq) eWe = (sA3 != 0);
        else           eWe = 1'b0;
        checkOutput({tag, "_ack"}, {31'b0, sAck}, {31'b0, eAck});
        checkOutput({tag, "_we"},  {31'b0, grfWe}, {31'b0, eWe});
        checkOutput({tag, "_a3"},  {27'b0, grfA3}, {27'b0, sWins ? sA3 : pA3});
        checkOutput({tag, "_wd"},  grfWd, sWins ? sWd : pWd);
        checkOutput({tag, "_pc"},  grfPc, sWins ? sPc : pPc);
    endtask

    // One clock edge: advance the model, then compare registered outputs
    task automatic tick(input string tag);
        logic ack;
        logic refused;
        ack     = reset && !pWe && sReq;
        refused = sReq && !ack;
        @(posedge clk);
        if (reset) begin
            mStreak = refused ? mStreak + 1 : 0;
            if (ack && sA3 != 0) mBusy[sA3] = 1'b0;
            if (allocWe && allocA3 != 0) mBusy[allocA3] = 1'b1;
        end
        #1;
        checkOutput({tag, "_busy"},  busy, mBusy);
        checkOutput({tag, "_stall"}, {31'b0, stall}, (mStreak >= MAX_WAIT) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic ackNow;
        testsRun    = 0;
        testsFailed = 0;
        mBusy       = '0;
        mStreak     = 0;

        // Reset holds everything quiet even with both requesters active
        reset = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'h1234, 32'h100, 1'b1, 5'd8, 32'hBEEF, 32'h200, 1'b0, 5'd0);
        #2;
        checkOutput("rst_busy",  busy, 32'h0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_ack",   {31'b0, sAck}, 32'd0);
        checkOutput("rst_we",    {31'b0, grfWe}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Primary write alone
        applyStimulus(1'b1, 5'd5, 32'h1234, 32'h100, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("t1_we",  {31'b0, grfWe}, 32'd1);
        checkOutput("t1_a3",  {27'b0, grfA3}, 32'd5);
        checkOutput("t1_wd",  grfWd, 32'h1234);
        checkOutput("t1_ack", {31'b0, sAck}, 32'd0);
        checkComb("t1");
        tick("t1");
        checkOutput("t1_busy0", busy, 32'h0);

        // Allocate $8, then the secondary completes it
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8);
        #1; checkComb("t2a"); tick("t2a");
        checkOutput("t2_busy_set", busy, 32'h0000_0100);
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8, 32'hBEEF, 32'h400, 1'b0, 5'd0);
        #1;
        checkOutput("t2_ack", {31'b0, sAck}, 32'd1);
        checkOutput("t2_wd",  grfWd, 32'hBEEF);
        checkComb("t2b"); tick("t2b");
        checkOutput("t2_busy_clr", busy, 32'h0);

        // Starvation: four refused edges raise the stall, which persists under a violating primary
        applyStimulus(1'b1, 5'd3, 32'h11, 32'h500, 1'b1, 5'd9, 32'h99, 32'h600, 1'b0, 5'd0);
        for (int i = 1; i <= MAX_WAIT + 1; i++) begin
            #1; checkComb("t3w"); tick("t3w");
            checkOutput("t3_stall_seq", {31'b0, stall}, (i >= MAX_WAIT) ? 32'd1 : 32'd0);
        end
        pWe = 1'b0;
        #1;
        checkOutput("t3_ack", {31'b0, sAck}, 32'd1);
        checkComb("t3r"); tick("t3r");
        checkOutput("t3_stall_clr", {31'b0, stall}, 32'd0);

        // Secondary write to $0 is acked but not written; set beats clear on $8
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h700, 1'b0, 5'd0);
        #1;
        checkOutput("t4_ack0", {31'b0, sAck}, 32'd1);
        checkOutput("t4_we0",  {31'b0, grfWe}, 32'd0);
        tick("t4a");
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8);
        #1; tick("t4b");
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8, 32'h55, 32'h800, 1'b1, 5'd8);
        #1; checkComb("t4c"); tick("t4c");
        checkOutput("t4_busy8", {31'b0, busy[8]}, 32'd1);

        // Asynchronous reset in the middle of a wait
        applyStimulus(1'b1, 5'd4, 32'h44, 32'h900, 1'b1, 5'd10, 32'hA0, 32'hA00, 1'b1, 5'd11);
        #1; tick("t5a");
        allocWe = 1'b0;
        #1; tick("t5b");
        #2;
        reset = 1'b0;
        pWe   = 1'b0;
        #1;
        checkOutput("t5_busy",  busy, 32'h0);
        checkOutput("t5_stall", {31'b0, stall}, 32'd0);
        checkOutput("t5_ack",   {31'b0, sAck}, 32'd0);
        checkOutput("t5_we",    {31'b0, grfWe}, 32'd0);
        mBusy   = '0;
        mStreak = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        pWe   = 1'b1;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            #1; tick("t5w");
            checkOutput("t5_idle_seq", {31'b0, stall}, (i >= MAX_WAIT) ? 32'd1 : 32'd0);
        end
        pWe = 1'b0;
        #1; checkComb("t5r"); tick("t5r");

        // Randomized traffic; a secondary request stays stable until acked
        sReq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!sReq && $urandom_range(0, 1) == 1) begin
                sReq = 1'b1;
                sA3  = 5'($urandom_range(0, 31));
                sWd  = $urandom;
                sPc  = $urandom;
            end
            pWe     = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            pA3     = 5'($urandom_range(0, 31));
            pWd     = $urandom;
            pPc     = $urandom;
            allocWe = ($urandom_range(0, 3) == 0);
            allocA3 = 5'($urandom_range(0, 31));
            #1;
            checkComb("rnd");
            ackNow = !pWe && sReq;
            tick("rnd");
            if (ackNow) sReq = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
